// File: rtl/rf_rdser_pkg.sv
// Shared parameters and FSM state encoding for the register-file read serializer.
package rf_rdser_pkg;
    localparam int RF_W  = 64;   // register width
    localparam int RF_N  = 8;    // number of registers
    localparam int RF_IW = 3;    // register index width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/rf_rdser_if.sv
// Beat stream from the serializer to its consumer (valid/ready handshake).
interface rf_rdser_if #(parameter int W = 64);
    logic [W-1:0] dout;
    logic [2:0]   didx;
    logic         dvalid;
    logic         dready;
    logic         dlast;

    modport master (output dout, didx, dvalid, dlast, input dready);
    modport slave  (input dout, didx, dvalid, dlast, output dready);
endinterface

// File: rtl/rf_rdser_pri_enc8.sv
// Lowest-set-bit priority encoder; is_last flags a single remaining bit.
module pri_enc8 (
    input  logic [7:0] vector,
    output logic [2:0] idx,
    output logic       any,
    output logic       is_last
);
    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (vector[i]) idx = 3'(i);
        end
    end

    assign any     = |vector;
    // Clearing the lowest set bit leaves zero only when one bit was set.
    assign is_last = any && ((vector & (vector - 8'd1)) == 8'd0);
endmodule

// File: rtl/rf_rdser.sv
// Register-file read serializer: snapshots the register image and mask on
// start, then streams the selected registers in ascending index order.
module rf_rdser
    import rf_rdser_pkg::*;
#(
    parameter int W = RF_W,
    parameter int N = RF_N
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [N*W-1:0]    q,
    input  logic              start,
    input  logic [N-1:0]      mask,
    output logic              busy,
    output logic              done,
    rf_rdser_if.master        dbus
);
    state_e           state_q, state_d;
    logic [N*W-1:0]   snap_q, snap_d;
    logic [N-1:0]     rem_q, rem_d;

    logic [7:0]       enc_vec;
    logic [2:0]       enc_idx;
    logic             enc_any;
    logic             enc_last;
    logic             dvalid;
    logic [W-1:0]     dout_sel;

    // Remaining-mask padded to the encoder width; unused upper bits stay 0.
    always_comb begin
        enc_vec          = '0;
        enc_vec[N-1:0]   = rem_q;
    end

    pri_enc8 u_enc (
        .vector  (enc_vec),
        .idx     (enc_idx),
        .any     (enc_any),
        .is_last (enc_last)
    );

    // State, snapshot and remaining-mask registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            snap_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state logic: capture on start, retire one mask bit per transfer.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (mask != '0) begin
                        snap_d  = q;
                        rem_d   = mask;
                        state_d = SEND;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SEND: begin
                if (!enc_any) begin
                    state_d = DONE;
                end else if (dbus.dready) begin
                    for (int i = 0; i < N; i++) begin
                        if (enc_idx == 3'(i)) rem_d[i] = 1'b0;
                    end
                    if (enc_last) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat data comes from the snapshot word selected by the current index.
    always_comb begin
        dout_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (enc_idx == 3'(i)) dout_sel = snap_q[N*W-1-i*W -: W];
        end
    end

    // Outputs decode from state so reset clears them immediately;
    // beat fields are forced to zero whenever no beat is offered.
    always_comb begin
        dvalid      = (state_q == SEND) && enc_any;
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        dbus.dvalid = dvalid;
        dbus.dout   = dvalid ? dout_sel : '0;
        dbus.didx   = dvalid ? enc_idx  : '0;
        dbus.dlast  = dvalid && enc_last;
    end
endmodule

// File: tb/tb_rf_rdser.sv
// Scoreboard bench for rf_rdser: expected beats are queued from a simple
// per-register model at start; a negedge monitor checks every transfer.
module tb_rf_rdser;
    localparam int W = 64;
    localparam int N = 8;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
        bit           last;
    } beat_t;

    logic           clk;
    logic           rst_b;
    logic [N*W-1:0] q;
    logic           start;
    logic [N-1:0]   mask;
    logic           busy;
    logic           done;

    rf_rdser_if #(.W(W)) dbus ();

    rf_rdser #(.W(W), .N(N)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .q     (q),
        .start (start),
        .mask  (mask),
        .busy  (busy),
        .done  (done),
        .dbus  (dbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    exp_done = 0;
    int    done_seen = 0;
    beat_t sb[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] reg_of(input logic [N*W-1:0] img, input int i);
        return img[N*W-1-i*W -: W];
    endfunction

    // Reference: one beat per set mask bit, ascending, last at the top bit.
    task automatic model_push(input logic [N*W-1:0] img, input logic [N-1:0] m);
        int hi;
        beat_t b;
        hi = -1;
        for (int i = 0; i < N; i++) if (m[i]) hi = i;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                b.idx  = i;
                b.data = reg_of(img, i);
                b.last = (i == hi);
                sb.push_back(b);
            end
        end
    endtask

    task automatic rand_q();
        for (int b = 0; b < N*W; b += 32) q[b +: 32] = $urandom;
    endtask

    // Monitor: idle beat fields are zero, stalled beats hold, transfers match.
    bit    hold_v = 0;
    beat_t held;
    always @(negedge clk) begin
        if (!rst_b) begin
            hold_v = 0;
        end else begin
            if (done) done_seen++;
            if (!dbus.dvalid) begin
                chk("idle_zero", {dbus.dout, 3'(dbus.didx), dbus.dlast} == '0 ? 1'b0 : 1'b1, 1'b0);
                hold_v = 0;
            end else begin
                if (hold_v) begin
                    chk("stall_dout", dbus.dout, held.data);
                    chk("stall_didx", W'(dbus.didx), W'(held.idx));
                    chk("stall_dlast", W'(dbus.dlast), W'(held.last));
                end
                if (dbus.dready) begin
                    hold_v = 0;
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", W'(dbus.didx), W'(8'hFF));
                    end else begin
                        beat_t e;
                        e = sb.pop_front();
                        chk("beat_didx", W'(dbus.didx), W'(e.idx));
                        chk("beat_dout", dbus.dout, e.data);
                        chk("beat_dlast", W'(dbus.dlast), W'(e.last));
                    end
                end else begin
                    hold_v    = 1;
                    held.idx  = int'(dbus.didx);
                    held.data = dbus.dout;
                    held.last = dbus.dlast;
                end
            end
        end
    end

    // mode 0: dready=1, timing checked; 1: random dready/q/start churn;
    // 2: 3-cycle stall on first beat with q changed; 3: start re-pulsed in SEND.
    task automatic xfer(input logic [N-1:0] m, input int mode);
        int pc, busy_cnt, dv_cnt, done_cyc, stall_left;
        bit got_done;
        pc = $countones(m);
        busy_cnt = 0; dv_cnt = 0; done_cyc = 0; got_done = 0; stall_left = 3;
        model_push(q, m);
        exp_done++;
        @(posedge clk); #1;
        start = 1'b1; mask = m; dbus.dready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mask = N'($urandom);
        if (mode == 0) chk("first_latency", W'(dbus.dvalid), W'(m != '0));
        for (int c = 1; c <= 400; c++) begin
            start = 1'b0;
            if (busy) busy_cnt++;
            if (dbus.dvalid) dv_cnt++;
            if (done) begin got_done = 1; done_cyc = c; break; end
            case (mode)
                1: begin
                    dbus.dready = ($urandom_range(2, 0) != 0);
                    if ($urandom_range(3, 0) == 0) rand_q();
                    if ($urandom_range(7, 0) == 0) begin start = 1'b1; mask = N'($urandom); end
                end
                2: begin
                    if (dbus.dvalid && stall_left > 0) begin
                        dbus.dready = 1'b0; stall_left--; rand_q();
                    end else dbus.dready = 1'b1;
                end
                3: begin
                    dbus.dready = 1'b1;
                    if (c == 1) begin start = 1'b1; mask = ~m; rand_q(); end
                end
                default: dbus.dready = 1'b1;
            endcase
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done_seen", W'(got_done), W'(1));
        if (mode == 0) begin
            chk("busy_cycles", W'(busy_cnt), W'(pc + 1));
            chk("dvalid_cycles", W'(dv_cnt), W'(pc));
            chk("done_cycle", W'(done_cyc), W'(pc + 1));
        end
        @(posedge clk); #1;
        chk("idle_busy", W'(busy), W'(0));
        chk("done_one_cycle", W'(done), W'(0));
        chk("sb_drained", W'(sb.size()), W'(0));
    endtask

    initial begin
        rst_b = 1'b0; start = 1'b0; mask = '0; q = '0; dbus.dready = 1'b0;
        #12;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_dvalid", W'(dbus.dvalid), W'(0));
        chk("rst_dout", dbus.dout, '0);
        chk("rst_didx", W'(dbus.didx), W'(0));
        chk("rst_dlast", W'(dbus.dlast), W'(0));
        @(posedge clk); #2;
        rst_b = 1'b1;

        for (int i = 0; i < N; i++) q[N*W-1-i*W -: W] = 64'h1111_1111_1111_1111 * i;
        xfer(8'hFF, 0);
        xfer(8'b1010_0100, 0);
        xfer(8'h00, 0);
        rand_q();
        xfer(8'h03, 2);
        rand_q();
        xfer(8'h5A, 3);

        // Reset during beat 3 of a full transfer: abort, no done pulse.
        rand_q();
        model_push(q, 8'hFF);
        @(posedge clk); #1;
        start = 1'b1; mask = 8'hFF; dbus.dready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            bit hit;
            hit = 0;
            for (int c = 0; c < 20; c++) begin
                if (dbus.dvalid && dbus.didx == 3'd3) begin hit = 1; break; end
                @(posedge clk); #1;
            end
            chk("reach_beat3", W'(hit), W'(1));
        end
        #1 rst_b = 1'b0;
        #1;
        chk("abort_dvalid", W'(dbus.dvalid), W'(0));
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_done", W'(done), W'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #2 rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_after_abort", W'(done_seen), W'(exp_done));
        rand_q();
        xfer(8'h80, 0);

        for (int t = 0; t < 25; t++) begin
            logic [N-1:0] m;
            m = ($urandom_range(4, 0) == 0) ? '0 : N'($urandom);
            rand_q();
            xfer(m, 1);
        end

        @(posedge clk); #1;
        chk("done_total", W'(done_seen), W'(exp_done));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
